scan_chain_controller: RTL and testbench

Sequencer for the team's N-flop scan chain (default 8, the `Scan_Chain_Design` chain). It accepts a parallel test pattern on a start pulse. It drives `scan_in`/`scan_en` to shift the pattern in MSB-first, issues one capture cycle, then shifts the chain out while assembling the parallel response. It compares the response against an expected value and keeps a saturating mismatch count, so a top-level FSM or bench can run patterns without bit-level stimulus.

---
 rtl/scan_chain_controller_if.sv | 27 ++
 rtl/scan_chain_controller.sv | 119 +++++++++++
 tb/tb_scan_chain_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/scan_chain_controller_if.sv
// Bus between the scan-chain sequencer and its user: test request, chain serial pins, results.
interface scan_chain_controller_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [N-1:0]     pattern;
  logic [N-1:0]     expected;
  logic             scan_out;
  logic             scan_in;
  logic             scan_en;
  logic             busy;
  logic             done;
  logic [N-1:0]     result;
  logic             match;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output start, pattern, expected, scan_out,
    input  scan_in, scan_en, busy, done, result, match, err_cnt
  );

  modport slave (
    input  start, pattern, expected, scan_out,
    output scan_in, scan_en, busy, done, result, match, err_cnt
  );
endinterface

// File: rtl/scan_chain_controller.sv
// Shifts a parallel pattern into an N-flop scan chain, captures once, shifts the response
// out, compares it with the golden value and keeps a saturating mismatch count.
module scan_chain_controller #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  scan_chain_controller_if.slave bus
);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [N-1:0]     r_shift, w_shift_nxt;
  logic [N-1:0]     r_exp, w_exp_nxt;
  logic [N-1:0]     r_resp, w_resp_nxt;
  logic [N-1:0]     r_result, w_result_nxt;
  logic             r_match, w_match_nxt;
  logic [CNT_W-1:0] r_err_cnt, w_err_nxt;
  logic [N-1:0]     w_sample;

  // Response register with the current (pre-shift) chain output appended
  assign w_sample = {r_resp[N-2:0], bus.scan_out};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_exp     <= '0;
      r_resp    <= '0;
      r_result  <= '0;
      r_match   <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_exp     <= w_exp_nxt;
      r_resp    <= w_resp_nxt;
      r_result  <= w_result_nxt;
      r_match   <= w_match_nxt;
      r_err_cnt <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_exp_nxt    = r_exp;
    w_resp_nxt   = r_resp;
    w_result_nxt = r_result;
    w_match_nxt  = r_match;
    w_err_nxt    = r_err_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_SHIFT_IN;
          w_shift_nxt = bus.pattern;
          w_exp_nxt   = bus.expected;
          w_cnt_nxt   = '0;
        end
      end
      S_SHIFT_IN: begin
        w_shift_nxt = {r_shift[N-2:0], 1'b0};
        if (r_cnt == LAST) begin
          w_state_nxt = S_CAPTURE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_CAPTURE: begin
        w_state_nxt = S_SHIFT_OUT;
      end
      S_SHIFT_OUT: begin
        w_resp_nxt = w_sample;
        if (r_cnt == LAST) begin
          w_state_nxt  = S_DONE;
          w_cnt_nxt    = '0;
          w_result_nxt = w_sample;
          w_match_nxt  = (w_sample == r_exp);
          if ((w_sample != r_exp) && (r_err_cnt != {CNT_W{1'b1}})) begin
            w_err_nxt = r_err_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Chain-side strobes depend on registered state only
  assign bus.scan_en = (r_state == S_SHIFT_IN) || (r_state == S_SHIFT_OUT);
  assign bus.scan_in = (r_state == S_SHIFT_IN) && r_shift[N-1];
  assign bus.busy    = (r_state == S_SHIFT_IN) || (r_state == S_CAPTURE) ||
                       (r_state == S_SHIFT_OUT);
  assign bus.done    = (r_state == S_DONE);
  assign bus.result  = r_result;
  assign bus.match   = r_match;
  assign bus.err_cnt = r_err_cnt;
endmodule

// File: tb/tb_scan_chain_controller.sv
// Directed bench: an 8-flop chain model whose capture loads the inverse of its contents.
module tb_scan_chain_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] chain = 8'h00;

  scan_chain_controller_if #(.N(8), .CNT_W(8)) ifc ();

  scan_chain_controller #(.N(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  // Chain model: shift on scan_en, otherwise capture the inverted contents
  always @(posedge clk) begin
    if (ifc.scan_en) chain <= {chain[6:0], ifc.scan_in};
    else             chain <= ~chain;
  end
  assign ifc.scan_out = chain[7];

  typedef struct {
    logic [7:0] pat;
    logic [7:0] exv;
    logic [7:0] res;
    logic       mt;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl [6];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One test from a start pulse to done; optionally checks the per-cycle chain strobes
  task automatic run_test(input logic [7:0] pat, input logic [7:0] exv, input bit chk_seq);
    logic [16:0] en_obs;
    logic [16:0] busy_obs;
    logic [7:0]  in_obs;
    logic        in_late;
    logic        busy_at_done;
    int          done_k;
    en_obs = '0; busy_obs = '0; in_obs = '0; in_late = 1'b0; busy_at_done = 1'b1;
    done_k = -1;
    @(negedge clk);
    ifc.start = 1'b1; ifc.pattern = pat; ifc.expected = exv;
    for (int k = 0; k < 40 && done_k < 0; k++) begin
      @(negedge clk);
      if (k == 0) ifc.start = 1'b0;
      if (ifc.done) begin
        done_k = k;
        busy_at_done = ifc.busy;
      end else if (k < 17) begin
        en_obs[k]   = ifc.scan_en;
        busy_obs[k] = ifc.busy;
        if (k < 8) in_obs[7-k] = ifc.scan_in;
        else       in_late = in_late | ifc.scan_in;
      end
    end
    chk("done_latency", 32'(done_k), 32'd17);
    if (chk_seq) begin
      chk("scan_en_seq", 32'(en_obs), 32'h1FEFF);
      chk("scan_in_seq", 32'(in_obs), 32'(pat));
      chk("scan_in_zero_after", 32'(in_late), 32'd0);
      chk("busy_seq", 32'(busy_obs), 32'h1FFFF);
      chk("busy_in_done", 32'(busy_at_done), 32'd0);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({ifc.scan_in, ifc.scan_en, ifc.busy, ifc.done, ifc.match,
                ifc.result, ifc.err_cnt});
  endfunction

  initial begin
    int d1, d2, nd;
    logic [7:0] r1, r2;
    logic m1, m2, saw_done;

    tbl[0] = '{pat: 8'hA5, exv: 8'h5A, res: 8'h5A, mt: 1'b1, ec: 8'd0};
    tbl[1] = '{pat: 8'h0F, exv: 8'hF0, res: 8'hF0, mt: 1'b1, ec: 8'd0};
    tbl[2] = '{pat: 8'h0F, exv: 8'h00, res: 8'hF0, mt: 1'b0, ec: 8'd1};
    tbl[3] = '{pat: 8'h00, exv: 8'hFF, res: 8'hFF, mt: 1'b1, ec: 8'd1};
    tbl[4] = '{pat: 8'hFF, exv: 8'hFF, res: 8'h00, mt: 1'b0, ec: 8'd2};
    tbl[5] = '{pat: 8'h3C, exv: 8'hC3, res: 8'hC3, mt: 1'b1, ec: 8'd2};

    ifc.start = 1'b0; ifc.pattern = '0; ifc.expected = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", all_outs(), 32'd0);

    // Table: first entry also checks the serial strobe sequence
    for (int i = 0; i < 6; i++) begin
      run_test(tbl[i].pat, tbl[i].exv, i == 0);
      chk($sformatf("result[%0d]", i), 32'(ifc.result), 32'(tbl[i].res));
      chk($sformatf("match[%0d]", i), 32'(ifc.match), 32'(tbl[i].mt));
      chk($sformatf("err_cnt[%0d]", i), 32'(ifc.err_cnt), 32'(tbl[i].ec));
      if (i == 0) begin
        @(negedge clk);
        chk("done_one_cycle", 32'(ifc.done), 32'd0);
      end
    end

    // start held high: back-to-back tests, mid-test input changes ignored
    @(negedge clk);
    ifc.start = 1'b1; ifc.pattern = 8'h81; ifc.expected = 8'h7E;
    d1 = -1; d2 = -1; nd = 0; r1 = '0; r2 = '0; m1 = 1'b0; m2 = 1'b0;
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      if (ifc.done) begin
        nd++;
        if (d1 < 0) begin d1 = k; r1 = ifc.result; m1 = ifc.match; end
        else begin d2 = k; r2 = ifc.result; m2 = ifc.match; end
      end
      if (k == 1) begin ifc.pattern = 8'h0F; ifc.expected = 8'hF0; end
      if (k == 36) ifc.start = 1'b0;
    end
    chk("held_done_count", 32'(nd), 32'd2);
    chk("held_done1_cycle", 32'(d1), 32'd17);
    chk("held_done2_cycle", 32'(d2), 32'd36);
    chk("held_result1", 32'(r1), 32'h7E);
    chk("held_match1", 32'(m1), 32'd1);
    chk("held_result2", 32'(r2), 32'hF0);
    chk("held_match2", 32'(m2), 32'd1);
    chk("held_err_cnt", 32'(ifc.err_cnt), 32'd2);

    // Reset during the third SHIFT_OUT cycle
    @(negedge clk);
    ifc.start = 1'b1; ifc.pattern = 8'h55; ifc.expected = 8'h00;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) ifc.start = 1'b0;
    end
    chk("busy_before_reset", 32'(ifc.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", all_outs(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      saw_done = saw_done | ifc.done;
    end
    chk("no_done_after_reset", 32'(saw_done), 32'd0);
    run_test(8'h3C, 8'hC3, 1'b1);
    chk("post_reset_result", 32'(ifc.result), 32'hC3);
    chk("post_reset_match", 32'(ifc.match), 32'd1);
    chk("post_reset_err_cnt", 32'(ifc.err_cnt), 32'd0);

    // Saturation of the mismatch counter
    for (int i = 0; i < 257; i++) begin
      run_test(8'h00, 8'h00, 1'b0);
      if (i == 253) chk("err_cnt_254", 32'(ifc.err_cnt), 32'hFE);
      if (i == 254) chk("err_cnt_255", 32'(ifc.err_cnt), 32'hFF);
    end
    chk("err_cnt_saturated", 32'(ifc.err_cnt), 32'hFF);
    chk("sat_result", 32'(ifc.result), 32'hFF);
    chk("sat_match", 32'(ifc.match), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
